sm_dmem_mmio: RTL
=================

// Module: sm_dmem_mmio
// PURPOSE
//  Data-memory subsystem on the CPU's M-stage port (dmAddr/dmWe/dmWData/dmRData).
//  Decodes each access to word RAM or a memory-mapped block: GPIO, cycle timer
//  with compare flag, and a TX byte FIFO with valid/ready output. Reads are combinational
//  (captured by the CPU at the M->W edge); writes commit on the rising clock edge.
// PARAMETERS
//  RAM_AW    8   RAM word-address width (2**RAM_AW words)
//  GPIO_W    16  GPIO in/out width
//  TX_AW     3   TX FIFO address width (depth 2**TX_AW)
// PORTS
//  clk       in   1       clock
//  rst_n     in   1       async active-low reset
//  dmAddr    in   32      byte address; bits [1:0] ignored
//  dmWe      in   1       write strobe, 1 cycle per store
//  dmWData   in   32      store data
//  dmRData   out  32      load data, combinational from dmAddr
//  gpioIn    in   GPIO_W  async external inputs
//  gpioOut   out  GPIO_W  output register
//  txData    out  8       FIFO head byte
//  txValid   out  1       FIFO non-empty
//  txReady   in   1       consumer pops head when txValid && txReady at posedge
//  irqMatch  out  1       copy of STATUS.match
// BEHAVIOUR
//  Clock clk, reset rst_n: one clock; reset is asynchronous and active-low.
//  Decode: dmAddr[31]=0 -> RAM word dmAddr[RAM_AW+1:2] (upper bits aliased); =1 -> MMIO reg dmAddr[4:2].
//  MMIO map (word index): 0 GPIO_OUT rw; 1 GPIO_IN ro; 2 CYCLE ro, any write clears;
//   3 CMP rw; 4 STATUS; 5 TXDATA wo (push dmWData[7:0]); 6,7 read 0, writes ignored.
//  STATUS bits: [0] match sticky, [1] txFull, [2] txEmpty, [3] txOvf sticky; write 1 to [0]/[3] clears.
//  Reset: gpioOut=0, CYCLE=0, CMP=32'hFFFF_FFFF, match=0, txOvf=0, FIFO empty (txValid=0),
//   GPIO sync flops=0, irqMatch=0. RAM contents not reset.
//  RAM: read same cycle; load in cycle after store to same word returns new data;
//   load and store in one cycle (not issued by CPU) return old data.
//  GPIO_IN: 2-flop synchroniser; 2-cycle latency from gpioIn to readable value.
//  CYCLE: +1 every cycle, wraps 32'hFFFF_FFFF->0; write-clear makes it 0 next cycle, then counts.
//  match: set in the cycle CYCLE==CMP; set and write-1-clear same cycle -> set wins.
//  FIFO push on dmWe to TXDATA; pop on txValid&&txReady. Push while full: data dropped,
//   txOvf set. Push+pop same cycle when full: pop then push, both succeed, no overflow.
//   Push+pop when empty: not possible (txValid=0); byte appears on txData next cycle.
//   Pointers wrap modulo 2**TX_AW with an extra bit for full/empty.
//  Reset mid-operation: all state above returns to reset values asynchronously; a push
//   in flight is lost.
// CONFIGURATION
//  SM_DMEM_TXFIFO_EN defined: TX FIFO built as above.
//  Not defined: no FIFO storage; TXDATA writes ignored; txValid=0, txData=0;
//   STATUS[1]=0, [2]=1, [3]=0; txReady ignored.
// STRUCTURE
//  Shared header sm_dmem.vh: MMIO index defines (SM_MMIO_GPIO_OUT..SM_MMIO_TXDATA),
//   STATUS bit positions, CMP reset value.
//  Sub-module sm_fifo_sync #(WIDTH, AW): synchronous FIFO with push/pop/full/empty;
//   instantiated only under SM_DMEM_TXFIFO_EN.
// TESTING
//  sw 0x0000_0010=0xDEAD_BEEF, lw next cycle -> dmRData 0xDEAD_BEEF; 0x0000_0012 reads same.
//  Write CYCLE, CMP=5 -> match/irqMatch=1 at CYCLE==5; write STATUS=1 same cycle -> stays 1.
//  gpioIn=0x00A5 -> GPIO_IN read 0x00A5 after 2 cycles; sw GPIO_OUT=0x1234 -> gpioOut 0x1234 next cycle.
//  txReady=0, push 9 bytes 0x01..0x09 (depth 8) -> STATUS=0xA (full+ovf); drain -> 0x01..0x08.
//  FIFO full, push 0x55 with txReady=1 -> no ovf, 0x55 emerges last.
//  rst_n low mid-burst -> txValid=0, gpioOut=0, CYCLE=0 immediately; macro off -> STATUS=0x4.

Source files
------------

// File: rtl/sm_dmem_mmio_pkg.sv
// Shared MMIO definitions for the data-memory subsystem: register indices, STATUS bit
// positions and reset constants.
package sm_dmem_mmio_pkg;

  // Word index within the MMIO window, taken from dmAddr[4:2].
  typedef enum logic [2:0] {
    MmioGpioOut = 3'd0,
    MmioGpioIn  = 3'd1,
    MmioCycle   = 3'd2,
    MmioCmp     = 3'd3,
    MmioStatus  = 3'd4,
    MmioTxData  = 3'd5,
    MmioRsvd6   = 3'd6,
    MmioRsvd7   = 3'd7
  } mmio_idx_e;

  localparam int unsigned StatusMatchBit   = 0;
  localparam int unsigned StatusTxFullBit  = 1;
  localparam int unsigned StatusTxEmptyBit = 2;
  localparam int unsigned StatusTxOvfBit   = 3;

  localparam logic [31:0] CmpRstVal = 32'hFFFF_FFFF;

  function automatic logic [31:0] pack_status(input logic match, input logic tx_full,
                                              input logic tx_empty, input logic tx_ovf);
    logic [31:0] s;
    s                   = '0;
    s[StatusMatchBit]   = match;
    s[StatusTxFullBit]  = tx_full;
    s[StatusTxEmptyBit] = tx_empty;
    s[StatusTxOvfBit]   = tx_ovf;
    return s;
  endfunction

endpackage

// File: rtl/sm_fifo_sync.sv
// Synchronous FIFO with extra-bit pointers. A push while full is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and flagged on push_drop_o.
module sm_fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_drop_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  assign empty_o     = (wptr_q == rptr_q);
  assign full_o      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok      = pop_i && !empty_o;
  // When full, the slot being popped this cycle is the one the push lands in.
  assign push_ok     = push_i && (!full_o || pop_ok);
  assign push_drop_o = push_i && !push_ok;
  assign rdata_o     = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + PtrOne;
    if (pop_ok)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sm_dmem_mmio.sv
// Data-memory subsystem: word RAM plus MMIO block (GPIO, cycle timer/compare, TX FIFO).
// Define SM_DMEM_TXFIFO_EN to build the TX byte FIFO; otherwise TXDATA is inert.
module sm_dmem_mmio
  import sm_dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned GPIO_W = 16,
  parameter int unsigned TX_AW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       dmAddr,
  input  logic              dmWe,
  input  logic [31:0]       dmWData,
  output logic [31:0]       dmRData,
  input  logic [GPIO_W-1:0] gpioIn,
  output logic [GPIO_W-1:0] gpioOut,
  output logic [7:0]        txData,
  output logic              txValid,
  input  logic              txReady,
  output logic              irqMatch
);

  logic              is_mmio;
  mmio_idx_e         reg_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_rdata;
  logic [31:0]       ram_q [2**RAM_AW];

  logic we_gpio_out, we_cycle, we_cmp, we_status, we_txdata;

  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_meta_q, gpio_sync_q;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       cmp_q, cmp_d;
  logic              match_q, match_d;
  logic              cmp_hit, match_vis;

  logic tx_full, tx_empty, tx_ovf;

  assign is_mmio = dmAddr[31];
  assign reg_idx = mmio_idx_e'(dmAddr[4:2]);
  assign ram_idx = dmAddr[RAM_AW+1:2];

  // RAM: combinational read, so a same-cycle store is only visible from the next cycle.
  always_ff @(posedge clk) begin
    if (dmWe && !is_mmio) ram_q[ram_idx] <= dmWData;
  end
  assign ram_rdata = ram_q[ram_idx];

  always_comb begin
    we_gpio_out = 1'b0;
    we_cycle    = 1'b0;
    we_cmp      = 1'b0;
    we_status   = 1'b0;
    we_txdata   = 1'b0;
    if (dmWe && is_mmio) begin
      unique case (reg_idx)
        MmioGpioOut: we_gpio_out = 1'b1;
        MmioCycle:   we_cycle    = 1'b1;
        MmioCmp:     we_cmp      = 1'b1;
        MmioStatus:  we_status   = 1'b1;
        MmioTxData:  we_txdata   = 1'b1;
        default:     ;
      endcase
    end
  end

  assign cmp_hit   = (cycle_q == cmp_q);
  // The flag is visible in the hit cycle itself; the register makes it sticky afterwards.
  assign match_vis = match_q | cmp_hit;
  assign irqMatch  = match_vis;
  assign gpioOut   = gpio_out_q;

  always_comb begin
    gpio_out_d = we_gpio_out ? dmWData[GPIO_W-1:0] : gpio_out_q;
    cycle_d    = we_cycle ? '0 : cycle_q + 32'd1;
    cmp_d      = we_cmp ? dmWData : cmp_q;
    // A fresh hit beats a write-1-clear in the same cycle.
    match_d    = cmp_hit | (match_q & ~(we_status & dmWData[StatusMatchBit]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q  <= '0;
      gpio_meta_q <= '0;
      gpio_sync_q <= '0;
      cycle_q     <= '0;
      cmp_q       <= CmpRstVal;
      match_q     <= 1'b0;
    end else begin
      gpio_out_q  <= gpio_out_d;
      gpio_meta_q <= gpioIn;
      gpio_sync_q <= gpio_meta_q;
      cycle_q     <= cycle_d;
      cmp_q       <= cmp_d;
      match_q     <= match_d;
    end
  end

`ifdef SM_DMEM_TXFIFO_EN
  logic tx_pop, tx_drop;
  logic tx_ovf_q, tx_ovf_d;

  assign txValid = !tx_empty;
  assign tx_pop  = txValid && txReady;

  sm_fifo_sync #(
    .WIDTH(8),
    .AW   (TX_AW)
  ) u_tx_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (we_txdata),
    .wdata_i    (dmWData[7:0]),
    .pop_i      (tx_pop),
    .rdata_o    (txData),
    .full_o     (tx_full),
    .empty_o    (tx_empty),
    .push_drop_o(tx_drop)
  );

  always_comb begin
    tx_ovf_d = tx_drop | (tx_ovf_q & ~(we_status & dmWData[StatusTxOvfBit]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_ovf_q <= 1'b0;
    else        tx_ovf_q <= tx_ovf_d;
  end

  assign tx_ovf = tx_ovf_q;
`else
  assign tx_full  = 1'b0;
  assign tx_empty = 1'b1;
  assign tx_ovf   = 1'b0;
  assign txValid  = 1'b0;
  assign txData   = '0;
`endif

  always_comb begin
    dmRData = '0;
    if (!is_mmio) begin
      dmRData = ram_rdata;
    end else begin
      unique case (reg_idx)
        MmioGpioOut: dmRData = 32'(gpio_out_q);
        MmioGpioIn:  dmRData = 32'(gpio_sync_q);
        MmioCycle:   dmRData = cycle_q;
        MmioCmp:     dmRData = cmp_q;
        MmioStatus:  dmRData = pack_status(match_vis, tx_full, tx_empty, tx_ovf);
        default:     dmRData = '0;
      endcase
    end
  end

  // Address bits outside the decode, and inputs that the FIFO-less build leaves idle.
  logic unused_sigs;
  assign unused_sigs = ^{dmAddr[30:RAM_AW+2], dmAddr[1:0], txReady, we_txdata};

endmodule
